mem_arbiter: RTL

//   Shares one single-port memory between the pipeline's instruction-fetch (I) and data-access (D) requesters.

---
 rtl/mem_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction-fetch (I) and data (D) requesters.
// Each access runs IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> RESP, with D priority and bounded I starvation.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ack,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_stall,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_wmask,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_stall,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_wmask,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                arb_busy
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STRK_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    count_reg, count_next;
  logic [STRK_W-1:0]   streak_reg, streak_next;
  logic                owner_reg, owner_next;   // 1 = D owns the in-flight access
  logic                we_reg, we_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic                mem_en_reg, mem_en_next;
  logic                mem_we_reg, mem_we_next;
  logic [MASK_W-1:0]   mem_wmask_reg, mem_wmask_next;
  logic                i_ack_reg, i_ack_next;
  logic                d_ack_reg, d_ack_next;
  logic [DATA_W-1:0]   i_rdata_reg, i_rdata_next;
  logic [DATA_W-1:0]   d_rdata_reg, d_rdata_next;
  logic                busy_reg, busy_next;
  logic                grant_d;

  // D normally wins; I is forced through once D has won STARVE_MAX times in a row over it.
  assign grant_d = d_req & ~(i_req & (streak_reg == STRK_W'(STARVE_MAX)));

  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    streak_next    = streak_reg;
    owner_next     = owner_reg;
    we_next        = we_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    mem_en_next    = 1'b0;
    mem_we_next    = 1'b0;
    mem_wmask_next = '0;
    i_ack_next     = 1'b0;
    d_ack_next     = 1'b0;
    i_rdata_next   = i_rdata_reg;
    d_rdata_next   = d_rdata_reg;
    case (state_reg)
      ST_IDLE: begin
        if (i_req || d_req) begin
          state_next  = ST_ISSUE;
          mem_en_next = 1'b1;
          if (grant_d) begin
            owner_next     = 1'b1;
            we_next        = d_we;
            addr_next      = d_addr;
            wdata_next     = d_wdata;
            mem_we_next    = d_we;
            mem_wmask_next = d_we ? d_wmask : '0;
            if (!i_req) begin
              streak_next = '0;
            end else if (streak_reg != STRK_W'(STARVE_MAX)) begin
              streak_next = streak_reg + 1'b1;
            end
          end else begin
            owner_next  = 1'b0;
            we_next     = 1'b0;
            addr_next   = i_addr;
            wdata_next  = '0;
            streak_next = '0;
          end
        end
      end
      ST_ISSUE: begin
        state_next = ST_WAIT;
        count_next = CNT_W'(MEM_LAT - 1);
      end
      ST_WAIT: begin
        if (count_reg == '0) begin
          state_next = ST_RESP;
          if (!we_reg) begin
            if (owner_reg) d_rdata_next = mem_rdata;
            else           i_rdata_next = mem_rdata;
          end
          d_ack_next = owner_reg;
          i_ack_next = ~owner_reg;
        end else begin
          count_next = count_reg - 1'b1;
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    busy_next = (state_next != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      count_reg     <= '0;
      streak_reg    <= '0;
      owner_reg     <= 1'b0;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_wmask_reg <= '0;
      i_ack_reg     <= 1'b0;
      d_ack_reg     <= 1'b0;
      i_rdata_reg   <= '0;
      d_rdata_reg   <= '0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      streak_reg    <= streak_next;
      owner_reg     <= owner_next;
      we_reg        <= we_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      mem_en_reg    <= mem_en_next;
      mem_we_reg    <= mem_we_next;
      mem_wmask_reg <= mem_wmask_next;
      i_ack_reg     <= i_ack_next;
      d_ack_reg     <= d_ack_next;
      i_rdata_reg   <= i_rdata_next;
      d_rdata_reg   <= d_rdata_next;
      busy_reg      <= busy_next;
    end
  end

  assign i_ack     = i_ack_reg;
  assign d_ack     = d_ack_reg;
  assign i_rdata   = i_rdata_reg;
  assign d_rdata   = d_rdata_reg;
  assign i_stall   = i_req & ~i_ack_reg;
  assign d_stall   = d_req & ~d_ack_reg;
  assign mem_en    = mem_en_reg;
  assign mem_we    = mem_we_reg;
  assign mem_wmask = mem_wmask_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign arb_busy  = busy_reg;

endmodule
